// File: rtl/hazard_pkg.sv
// Shared encodings and constants for the pipeline hazard/stall controller.
// No logic; no latency; no flow control.
package hazard_pkg;
   typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_e;

   localparam logic [4:0] REG_ZERO          = 5'd0;
   localparam int         MD_CYCLES_DEFAULT = 32;
   localparam int         MD_CNT_W          = 8;
endpackage

// File: rtl/md_latency_counter.sv
// Loadable down-counter with done flag, for fixed-latency mul/div sequencing.
// Count updates one cycle after load/dec; done is combinational from the count.
// No backpressure; holds at zero instead of wrapping.
module md_latency_counter
   import hazard_pkg::*;
#(
   parameter int W = MD_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_controller.sv
// Front-end hazard control: load-use stalls, branch flushes, mul/div occupancy.
// Enables/flush/bubble are combinational from state + inputs; state registered.
// Optional saturating stall/flush counters built only with HAZARD_PERF_CNT_EN.
module hazard_stall_controller
   import hazard_pkg::*;
#(
   parameter int MD_CYCLES = MD_CYCLES_DEFAULT,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_is_muldiv,
   input  logic [4:0]       id_ex_rt,
   input  logic             id_ex_mem_read,
   input  logic             ex_branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             md_start,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // Start cycle is counted by RUN, so BUSY spans MD_CYCLES-1 cycles.
   localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_CYCLES - 2);

   state_e state_q, state_d;
   logic   lu;
   logic   md_accept;
   logic   md_done;
   logic   in_busy;

   assign in_busy = (state_q == BUSY);

   assign lu = id_valid && id_ex_mem_read && (id_ex_rt != REG_ZERO) &&
               ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

   always_comb begin
      state_d      = state_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      md_accept    = 1'b0;
      if (rst_n) begin
         if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         // In the release cycle only another muldiv must wait; it is accepted from RUN.
         end else if (in_busy && id_valid && (!md_done || id_is_muldiv)) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end else if (!in_busy && id_valid && id_is_muldiv) begin
            md_accept = 1'b1;
         end

         if (md_accept) begin
            state_d = BUSY;
         end else if (in_busy && md_done) begin
            state_d = RUN;
         end
      end
   end

   assign md_start = md_accept;
   assign md_busy  = md_accept || in_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   md_latency_counter #(
      .W (MD_CNT_W)
   ) u_md_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (md_accept),
      .load_val_i (MD_LOAD),
      .dec_i      (in_busy),
      .done_o     (md_done)
   );

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (if_id_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: occupancy-count model checked every cycle,
// plus directed cases with literal expectations.
module tb_hazard_stall_controller;
   localparam int MDC  = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          id_valid, id_uses_rt, id_is_muldiv, id_ex_mem_read, ex_branch_taken;
   logic [4:0]    id_rs, id_rt, id_ex_rt;
   logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, md_start, md_busy;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_stall_controller #(
      .MD_CYCLES (MDC),
      .CNT_W     (CW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_valid        (id_valid),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .id_is_muldiv    (id_is_muldiv),
      .id_ex_rt        (id_ex_rt),
      .id_ex_mem_read  (id_ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .if_id_flush     (if_id_flush),
      .id_ex_bubble    (id_ex_bubble),
      .md_start        (md_start),
      .md_busy         (md_busy),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic md, input logic [4:0] exrt,
                        input logic mr, input logic br);
      @(posedge clk);
      #1;
      id_valid        = v;
      id_rs           = rs;
      id_rt           = rt;
      id_uses_rt      = urt;
      id_is_muldiv    = md;
      id_ex_rt        = exrt;
      id_ex_mem_read  = mr;
      ex_branch_taken = br;
   endtask

   // Model: md_left = mul/div cycles still to be occupied, this one included.
   int md_left = 0, nxt_left = 0;
   int sc_m = 0, fc_m = 0, nxt_sc = 0, nxt_fc = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_left = 0;
         sc_m    = 0;
         fc_m    = 0;
      end else begin
         md_left = nxt_left;
         sc_m    = nxt_sc;
         fc_m    = nxt_fc;
      end
   end

   always @(negedge clk) begin : cmp
      bit lu, occ, rel, e_pc, e_ifw, e_fl, e_bb, e_st, e_bz;
      int e_sc, e_fc;
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bb = 0; e_st = 0; e_bz = 0;
      if (!rst_n) begin
         nxt_left = 0;
         nxt_sc   = 0;
         nxt_fc   = 0;
      end else begin
         lu  = id_valid && id_ex_mem_read && (id_ex_rt != 0) &&
               ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
         occ = (md_left > 0);
         rel = (md_left == 1);
         if (ex_branch_taken) begin
            e_fl = 1; e_bb = 1;
         end else if (occ && id_valid && (!rel || id_is_muldiv)) begin
            e_pc = 0; e_ifw = 0; e_bb = 1;
         end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_bb = 1;
         end else if (!occ && id_valid && id_is_muldiv) begin
            e_st = 1;
         end
         e_bz     = occ || e_st;
         nxt_left = e_st ? MDC - 1 : (occ ? md_left - 1 : 0);
         nxt_sc   = (!e_pc && sc_m < CMAX) ? sc_m + 1 : sc_m;
         nxt_fc   = (e_fl && fc_m < CMAX) ? fc_m + 1 : fc_m;
      end
`ifdef HAZARD_PERF_CNT_EN
      e_sc = sc_m;
      e_fc = fc_m;
`else
      e_sc = 0;
      e_fc = 0;
`endif
      chk("pc_write",     int'(pc_write),     int'(e_pc));
      chk("if_id_write",  int'(if_id_write),  int'(e_ifw));
      chk("if_id_flush",  int'(if_id_flush),  int'(e_fl));
      chk("id_ex_bubble", int'(id_ex_bubble), int'(e_bb));
      chk("md_start",     int'(md_start),     int'(e_st));
      chk("md_busy",      int'(md_busy),      int'(e_bz));
      chk("stall_cnt",    int'(stall_cnt),    e_sc);
      chk("flush_cnt",    int'(flush_cnt),    e_fc);
   end

   initial begin
      id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_muldiv = 0;
      id_ex_rt = 0; id_ex_mem_read = 0; ex_branch_taken = 0;

      // Reset held with a branch and a muldiv presented.
      drive(1, 5'd8, 5'd8, 1, 1, 5'd8, 1, 1);
      @(negedge clk);
      chk("rst_flush", int'(if_id_flush), 0);
      chk("rst_pc",    int'(pc_write), 1);
      chk("rst_start", int'(md_start), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1 rst_n = 1'b1;

      // Load-use on rs: one stall, then the bubble in EX releases it.
      drive(1, 5'd8, 5'd3, 1, 0, 5'd8, 1, 0);
      @(negedge clk);
      chk("lu_pc",     int'(pc_write), 0);
      chk("lu_ifid",   int'(if_id_write), 0);
      chk("lu_bubble", int'(id_ex_bubble), 1);
      drive(1, 5'd8, 5'd3, 1, 0, 5'd0, 0, 0);
      @(negedge clk);
      chk("lu_after_pc",     int'(pc_write), 1);
      chk("lu_after_bubble", int'(id_ex_bubble), 0);

      // Load into $zero never stalls; rt match ignored when rt is not a source.
      drive(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0);
      @(negedge clk);
      chk("lu_zero_pc", int'(pc_write), 1);
      drive(1, 5'd4, 5'd9, 0, 0, 5'd9, 1, 0);
      @(negedge clk);
      chk("lu_rt_unused_pc", int'(pc_write), 1);

      // MULT with MD_CYCLES=4 followed by a dependent-free ADD.
      drive(1, 5'd1, 5'd2, 1, 1, 5'd20, 0, 0);
      @(negedge clk);
      chk("mult_c0_start", int'(md_start), 1);
      chk("mult_c0_busy",  int'(md_busy), 1);
      chk("mult_c0_pc",    int'(pc_write), 1);
      for (int c = 1; c <= 3; c++) begin
         drive(1, 5'd3, 5'd4, 1, 0, 5'd20, 0, 0);
         @(negedge clk);
         chk($sformatf("mult_c%0d_busy", c),  int'(md_busy), 1);
         chk($sformatf("mult_c%0d_start", c), int'(md_start), 0);
         chk($sformatf("mult_c%0d_pc", c),    int'(pc_write), (c == 3) ? 1 : 0);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mult_c4_busy", int'(md_busy), 0);

      // Branch beats both load-use and muldiv acceptance.
      drive(1, 5'd8, 5'd8, 1, 1, 5'd8, 1, 1);
      @(negedge clk);
      chk("br_flush",  int'(if_id_flush), 1);
      chk("br_bubble", int'(id_ex_bubble), 1);
      chk("br_pc",     int'(pc_write), 1);
      chk("br_start",  int'(md_start), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("br_no_busy", int'(md_busy), 0);

      // Asynchronous reset while BUSY aborts the operation.
      drive(1, 5'd1, 5'd2, 1, 1, 5'd20, 0, 0);
      drive(1, 5'd3, 5'd4, 1, 0, 5'd20, 0, 0);
      drive(1, 5'd3, 5'd4, 1, 0, 5'd20, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy",   int'(md_busy), 0);
      chk("arst_pc",     int'(pc_write), 1);
      chk("arst_bubble", int'(id_ex_bubble), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      drive(1, 5'd3, 5'd4, 1, 0, 5'd20, 0, 0);
      @(negedge clk);
      chk("arst_after_busy", int'(md_busy), 0);
      chk("arst_after_pc",   int'(pc_write), 1);

      // 20 consecutive load-use stalls saturate the 4-bit stall counter.
      repeat (20) drive(1, 5'd7, 5'd1, 1, 0, 5'd7, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt_sat", int'(stall_cnt), 15);
`else
      chk("stall_cnt_tied", int'(stall_cnt), 0);
`endif

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(7) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
               1'($urandom_range(1)), $urandom_range(3) == 0, 5'($urandom_range(3)),
               $urandom_range(2) == 0, $urandom_range(7) == 0);
         if ($urandom_range(299) == 0) begin
            #2 rst_n = 1'b0;
            @(posedge clk);
            #2 rst_n = 1'b1;
         end
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
